iobus_timer: RTL



---
 rtl/iobus_timer_if.sv | 25 ++
 rtl/iobus_timer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/iobus_timer_if.sv
// I/O-bus responder interface: stage-3a request signals and the stage-4a read-data return.
// The master drives strobes, address and write data; the slave returns registered read data.
interface iobus_timer_if;
  logic        rdstrobe_3a;
  logic        wrstrobe_3a;
  logic [7:0]  address_3a;
  logic [31:0] wrdata_3a;
  logic [31:0] rddata_4a;

  modport master (
    output rdstrobe_3a,
    output wrstrobe_3a,
    output address_3a,
    output wrdata_3a,
    input  rddata_4a
  );

  modport slave (
    input  rdstrobe_3a,
    input  wrstrobe_3a,
    input  address_3a,
    input  wrdata_3a,
    output rddata_4a
  );
endinterface

// File: rtl/iobus_timer.sv
// Prescaled 32-bit down-counter timer on the CPU I/O bus, with reload, a sticky expiry flag
// and a level interrupt. Read data is zero when not selected so responders can be OR-combined.
module iobus_timer #(
  parameter logic [7:0] BASE_ADDR = 8'h20
) (
  input  logic          clk,
  input  logic          rst_b,
  iobus_timer_if.slave  bus,
  output logic          timer__irq
);

  logic [2:0]  ctrl_r,     ctrl_s;
  logic [15:0] prescale_r, prescale_s;
  logic [31:0] load_r,     load_s;
  logic [31:0] count_r,    count_s;
  logic        expired_r,  expired_s;
  logic [15:0] psc_r,      psc_s;
  logic [31:0] rddata_r,   rddata_s;
  logic        irq_r,      irq_s;

  logic        hit_s, rd_s, wr_s, tick_s, expire_set_s;
  logic [2:0]  offset_s;
  logic        wr_ctrl_s, wr_prescale_s, wr_load_s, wr_count_s, wr_status_s;
  logic [31:0] rdmux_s;

  // Address decode, write-enable decode and read mux
  always_comb begin
    hit_s         = (bus.address_3a[7:3] == BASE_ADDR[7:3]);
    offset_s      = bus.address_3a[2:0];
    rd_s          = bus.rdstrobe_3a & hit_s;
    wr_s          = bus.wrstrobe_3a & hit_s;
    wr_ctrl_s     = 1'b0;
    wr_prescale_s = 1'b0;
    wr_load_s     = 1'b0;
    wr_count_s    = 1'b0;
    wr_status_s   = 1'b0;
    rdmux_s       = 32'd0;
    case (offset_s)
      3'd0: begin
        wr_ctrl_s = wr_s;
        rdmux_s   = {29'd0, ctrl_r};
      end
      3'd1: begin
        wr_prescale_s = wr_s;
        rdmux_s       = {16'd0, prescale_r};
      end
      3'd2: begin
        wr_load_s = wr_s;
        rdmux_s   = load_r;
      end
      3'd3: begin
        wr_count_s = wr_s;
        rdmux_s    = count_r;
      end
      3'd4: begin
        wr_status_s = wr_s;
        rdmux_s     = {31'd0, expired_r};
      end
      default: begin
        rdmux_s = 32'd0;
      end
    endcase
  end

  // Prescaler, counter, control and status next-state logic
  always_comb begin
    tick_s       = ctrl_r[0] & (psc_r == prescale_r);
    expire_set_s = tick_s & (count_r == 32'd1);

    prescale_s = wr_prescale_s ? bus.wrdata_3a[15:0] : prescale_r;
    load_s     = wr_load_s ? bus.wrdata_3a : load_r;

    // Reconfiguration restarts the prescale period from zero
    if (wr_ctrl_s || wr_prescale_s) begin
      psc_s = 16'd0;
    end else if (!ctrl_r[0] || tick_s) begin
      psc_s = 16'd0;
    end else begin
      psc_s = psc_r + 16'd1;
    end

    if (wr_count_s) begin
      count_s = bus.wrdata_3a;
    end else if (tick_s) begin
      if (count_r > 32'd1) begin
        count_s = count_r - 32'd1;
      end else if (count_r == 32'd1) begin
        count_s = 32'd0;
      end else if (ctrl_r[1]) begin
        count_s = load_r;
      end else begin
        count_s = count_r;
      end
    end else begin
      count_s = count_r;
    end

    if (wr_ctrl_s) begin
      ctrl_s = bus.wrdata_3a[2:0];
    end else if (tick_s && (count_r == 32'd0) && !ctrl_r[1]) begin
      ctrl_s = {ctrl_r[2:1], 1'b0};
    end else begin
      ctrl_s = ctrl_r;
    end

    // A fresh expiry wins over a same-cycle clear so no event is lost
    if (expire_set_s) begin
      expired_s = 1'b1;
    end else if (wr_status_s && bus.wrdata_3a[0]) begin
      expired_s = 1'b0;
    end else begin
      expired_s = expired_r;
    end

    rddata_s = rd_s ? rdmux_s : 32'd0;
    irq_s    = expired_s & ctrl_s[2];
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_r     <= 3'd0;
      prescale_r <= 16'd0;
      load_r     <= 32'd0;
      count_r    <= 32'd0;
      expired_r  <= 1'b0;
      psc_r      <= 16'd0;
      rddata_r   <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      ctrl_r     <= ctrl_s;
      prescale_r <= prescale_s;
      load_r     <= load_s;
      count_r    <= count_s;
      expired_r  <= expired_s;
      psc_r      <= psc_s;
      rddata_r   <= rddata_s;
      irq_r      <= irq_s;
    end
  end

  assign bus.rddata_4a = rddata_r;
  assign timer__irq    = irq_r;

endmodule
